// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU core: state encoding, opcode constants, and a
// decode helper that tells whether an opcode carries an address operand.
package mpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_OPERAND  = 3'd2,
    S_EXEC     = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_WAIT_OUT = 3'd5,
    S_HALT     = 3'd6
  } stateT;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JNZ = 4'hC;
  localparam logic [3:0] OP_IN  = 4'hD;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Memory-operand ops (LDA..XOR) and branches take a second word.
  function automatic logic hasOperand(input logic [3:0] op);
    return ((op >= OP_LDA) && (op <= OP_XOR)) || ((op >= OP_JMP) && (op <= OP_JNZ));
  endfunction

endpackage

// File: rtl/mpu_alu.sv
// Combinational ALU for the MPU core.
//   op         : opcode (IR[3:0])
//   a, b       : accumulator and second operand (memory word or input-port data)
//   res        : result to load into the accumulator
//   zero, sign : flags derived from res
//   carry      : carry-out (ADD) or borrow (SUB)
//   writeAcc   : op produces an accumulator/flag update
//   writeCarry : op also updates the carry flag
module mpu_alu
  import mpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              zero,
  output logic              sign,
  output logic              carry,
  output logic              writeAcc,
  output logic              writeCarry
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide       = '0;
    res        = '0;
    carry      = 1'b0;
    writeAcc   = 1'b1;
    writeCarry = 1'b0;
    case (op)
      OP_LDA, OP_IN: res = b;
      OP_ADD: begin
        wide       = {1'b0, a} + {1'b0, b};
        res        = wide[DATA_W-1:0];
        carry      = wide[DATA_W];
        writeCarry = 1'b1;
      end
      OP_SUB: begin
        // Extended subtraction: the top bit is set exactly when a < b.
        wide       = {1'b0, a} - {1'b0, b};
        res        = wide[DATA_W-1:0];
        carry      = wide[DATA_W];
        writeCarry = 1'b1;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_INC:  res = a + 1'b1;
      OP_DEC:  res = a - 1'b1;
      default: writeAcc = 1'b0;
    endcase
    zero = (res == '0);
    sign = res[DATA_W-1];
  end

endmodule

// File: rtl/mpu_core_p.sv
// Accumulator micro-processor with a unified program/data memory.
//   iClk, iRst (async active-low)
//   iStart                         : run from address 0 (IDLE/HALT only)
//   iLoadEn/iLoadAddr/iLoadData    : program-load write port (IDLE/HALT only)
//   iInData/iInValid/oInReady      : input-port handshake (IN)
//   oOutData/oOutValid/iOutReady   : output-port handshake (OUT)
//   oPC, oAcc, oIR, oState, oZero, oSign, oCarry, oHalt, oBusy : observation
module mpu_core_p
  import mpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iLoadEn,
  input  logic [ADDR_W-1:0] iLoadAddr,
  input  logic [DATA_W-1:0] iLoadData,
  input  logic [DATA_W-1:0] iInData,
  input  logic              iInValid,
  output logic              oInReady,
  output logic [DATA_W-1:0] oOutData,
  output logic              oOutValid,
  input  logic              iOutReady,
  output logic [ADDR_W-1:0] oPC,
  output logic [DATA_W-1:0] oAcc,
  output logic [DATA_W-1:0] oIR,
  output logic [2:0]        oState,
  output logic              oZero,
  output logic              oSign,
  output logic              oCarry,
  output logic              oHalt,
  output logic              oBusy
);

  localparam int DEPTH = 2 ** ADDR_W;

  stateT             state;
  logic [ADDR_W-1:0] pc, arg;
  logic [DATA_W-1:0] acc, ir;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] memAtPc, memAtArg, aluB, aluRes;
  logic [3:0]        op;
  logic              aluZero, aluSign, aluCarry, aluWriteAcc, aluWriteCarry;
  logic              loadOk;

  assign memAtPc  = mem[pc];
  assign memAtArg = mem[arg];
  assign op       = ir[3:0];
  assign loadOk   = (state == S_IDLE) || (state == S_HALT);
  // In WAIT_IN the IR still holds IN, so the ALU just passes the port data.
  assign aluB     = (state == S_WAIT_IN) ? iInData : memAtArg;

  mpu_alu #(.DATA_W(DATA_W)) uAlu (
    .op        (op),
    .a         (acc),
    .b         (aluB),
    .res       (aluRes),
    .zero      (aluZero),
    .sign      (aluSign),
    .carry     (aluCarry),
    .writeAcc  (aluWriteAcc),
    .writeCarry(aluWriteCarry)
  );

  // Memory is deliberately not reset; loads and STA share one write port.
  always_ff @(posedge iClk) begin
    if (loadOk && iLoadEn)
      mem[iLoadAddr] <= iLoadData;
    else if ((state == S_EXEC) && (op == OP_STA))
      mem[arg] <= acc;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state     <= S_IDLE;
      pc        <= '0;
      arg       <= '0;
      acc       <= '0;
      ir        <= '0;
      oOutData  <= '0;
      oZero     <= 1'b0;
      oSign     <= 1'b0;
      oCarry    <= 1'b0;
      oInReady  <= 1'b0;
      oOutValid <= 1'b0;
      oHalt     <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (iStart) begin
            pc    <= '0;
            oHalt <= 1'b0;
            oBusy <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= memAtPc;
          pc    <= pc + 1'b1;
          state <= hasOperand(memAtPc[3:0]) ? S_OPERAND : S_EXEC;
        end
        S_OPERAND: begin
          arg   <= memAtPc[ADDR_W-1:0];
          pc    <= pc + 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          // IN defers its accumulator update to the handshake.
          if (aluWriteAcc && (op != OP_IN)) begin
            acc   <= aluRes;
            oZero <= aluZero;
            oSign <= aluSign;
            if (aluWriteCarry) oCarry <= aluCarry;
          end
          case (op)
            OP_JMP: pc <= arg;
            OP_JZ:  if (oZero)  pc <= arg;
            OP_JNZ: if (!oZero) pc <= arg;
            OP_IN: begin
              oInReady <= 1'b1;
              state    <= S_WAIT_IN;
            end
            OP_OUT: begin
              oOutValid <= 1'b1;
              oOutData  <= acc;
              state     <= S_WAIT_OUT;
            end
            OP_HLT: begin
              oHalt <= 1'b1;
              oBusy <= 1'b0;
              state <= S_HALT;
            end
            default: ;
          endcase
        end
        S_WAIT_IN: begin
          if (iInValid && oInReady) begin
            acc      <= aluRes;
            oZero    <= aluZero;
            oSign    <= aluSign;
            oInReady <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_WAIT_OUT: begin
          if (iOutReady) begin
            oOutValid <= 1'b0;
            state     <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign oPC    = pc;
  assign oAcc   = acc;
  assign oIR    = ir;
  assign oState = state;

endmodule

// File: tb/tb_mpu_core_p.sv
module tb_mpu_core_p;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       rst = 1'b0, start = 1'b0, loadEn = 1'b0, inValid = 1'b0, outReady = 1'b0;
  logic [7:0] loadAddr = '0, loadData = '0, inData = '0;
  logic [7:0] outData, pc, acc, ir;
  logic [2:0] st;
  logic       inReady, outValid, zero, sign, carry, halt, busy;

  // 16-bit / 10-bit instance
  logic        rst16 = 1'b0, start16 = 1'b0, load16 = 1'b0;
  logic [9:0]  loadAddr16 = '0;
  logic [15:0] loadData16 = '0;
  logic [15:0] outData16, acc16, ir16;
  logic [9:0]  pc16;
  logic [2:0]  st16;
  logic        inReady16, outValid16, zero16, sign16, carry16, halt16, busy16;

  int checks = 0, errors = 0, xfers = 0, readyCycles = 0;

  mpu_core_p #(.DATA_W(8), .ADDR_W(8)) u8 (
    .iClk(clk), .iRst(rst), .iStart(start),
    .iLoadEn(loadEn), .iLoadAddr(loadAddr), .iLoadData(loadData),
    .iInData(inData), .iInValid(inValid), .oInReady(inReady),
    .oOutData(outData), .oOutValid(outValid), .iOutReady(outReady),
    .oPC(pc), .oAcc(acc), .oIR(ir), .oState(st),
    .oZero(zero), .oSign(sign), .oCarry(carry), .oHalt(halt), .oBusy(busy)
  );

  mpu_core_p #(.DATA_W(16), .ADDR_W(10)) u16 (
    .iClk(clk), .iRst(rst16), .iStart(start16),
    .iLoadEn(load16), .iLoadAddr(loadAddr16), .iLoadData(loadData16),
    .iInData(16'h0000), .iInValid(1'b0), .oInReady(inReady16),
    .oOutData(outData16), .oOutValid(outValid16), .iOutReady(1'b0),
    .oPC(pc16), .oAcc(acc16), .oIR(ir16), .oState(st16),
    .oZero(zero16), .oSign(sign16), .oCarry(carry16), .oHalt(halt16), .oBusy(busy16)
  );

  always @(posedge clk) begin
    if (outValid && outReady) xfers++;
    if (inReady) readyCycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic load16w(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    load16 = 1'b1; loadAddr16 = a; loadData16 = d;
    @(negedge clk);
    load16 = 1'b0;
  endtask

  // Returns at the negedge after the start edge: state FETCH, PC 0.
  task automatic run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitHalt(input string tag);
    int n = 0;
    while (!halt && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, halt, 1);
  endtask

  initial begin
    // ---- reset state
    #1;
    chk("rst_state", st, 0);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outvalid", outValid, 0);
    chk("rst_inready", inReady, 0);
    @(negedge clk);
    rst = 1'b1; rst16 = 1'b1;

    // ---- LDA 0x10, ADD 0x11, OUT, HLT with OUT backpressure
    load(8'h00, 8'h01); load(8'h01, 8'h10); load(8'h02, 8'h03); load(8'h03, 8'h11);
    load(8'h04, 8'h0E); load(8'h05, 8'h0F); load(8'h10, 8'h7F); load(8'h11, 8'h01);
    run();
    chk("start_busy", busy, 1);
    begin
      int n = 0;
      while (!outValid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("out_valid_rise", outValid, 1);
    for (int i = 0; i < 4; i++) begin
      chk("out_hold_valid", outValid, 1);
      chk("out_hold_data", outData, 8'h80);
      @(negedge clk);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    chk("out_valid_drop", outValid, 0);
    waitHalt("prog1_halt");
    chk("prog1_outdata", outData, 8'h80);
    chk("prog1_sign", sign, 1);
    chk("prog1_carry", carry, 0);
    chk("prog1_zero", zero, 0);
    chk("prog1_busy", busy, 0);
    chk("prog1_xfers", xfers, 1);

    // ---- ADD 0xFF+0x01 then JZ 0x20
    load(8'h00, 8'h01); load(8'h01, 8'h12); load(8'h02, 8'h03); load(8'h03, 8'h13);
    load(8'h04, 8'h0B); load(8'h05, 8'h20); load(8'h06, 8'h0F);
    load(8'h12, 8'hFF); load(8'h13, 8'h01); load(8'h20, 8'h0F);
    run();
    chk("run_clears_halt", halt, 0);
    repeat (9) @(negedge clk);
    chk("jz_pc", pc, 8'h20);
    chk("jz_state", st, 1);
    chk("add_acc", acc, 8'h00);
    chk("add_zero", zero, 1);
    chk("add_carry", carry, 1);
    waitHalt("prog2_halt");
    chk("prog2_pc", pc, 8'h21);

    // ---- IN with 5-cycle stall, SUB with borrow, JNZ taken
    load(8'h00, 8'h0D); load(8'h01, 8'h04); load(8'h02, 8'h14); load(8'h03, 8'h0C);
    load(8'h04, 8'h30); load(8'h05, 8'h0F); load(8'h14, 8'h3D); load(8'h30, 8'h0F);
    run();
    begin
      int n = 0;
      while (!inReady && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("in_ready_rise", inReady, 1);
    repeat (5) @(negedge clk);
    chk("in_stall_state", st, 4);
    inValid = 1'b1; inData = 8'h3C;
    @(negedge clk);
    inValid = 1'b0; inData = 8'h00;
    chk("in_acc", acc, 8'h3C);
    chk("in_ready_cycles", readyCycles, 6);
    chk("in_ready_drop", inReady, 0);
    waitHalt("prog3_halt");
    chk("sub_acc", acc, 8'hFF);
    chk("sub_borrow", carry, 1);
    chk("sub_sign", sign, 1);
    chk("jnz_pc", pc, 8'h31);

    // ---- load during EXEC ignored; reset in WAIT_OUT
    load(8'h00, 8'h0E); load(8'h01, 8'h0F); load(8'h40, 8'h11);
    run();
    @(negedge clk);
    chk("exec_state", st, 3);
    loadEn = 1'b1; loadAddr = 8'h40; loadData = 8'h55;
    @(negedge clk);
    loadEn = 1'b0;
    chk("wout_state", st, 5);
    chk("wout_valid", outValid, 1);
    chk("wout_data", outData, 8'hFF);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", st, 0);
    chk("arst_valid", outValid, 0);
    chk("arst_data", outData, 0);
    chk("arst_acc", acc, 0);
    chk("arst_busy", busy, 0);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    rst = 1'b1;
    chk("arst_no_xfer", xfers, 1);
    // load coinciding with start: first fetch must see the new word
    load(8'h00, 8'h0F); load(8'h01, 8'h40); load(8'h02, 8'h0F);
    @(negedge clk);
    start = 1'b1; loadEn = 1'b1; loadAddr = 8'h00; loadData = 8'h01;
    @(negedge clk);
    start = 1'b0; loadEn = 1'b0;
    waitHalt("prog4_halt");
    chk("mem_unchanged", acc, 8'h11);
    chk("prog4_pc", pc, 8'h03);

    // ---- 16-bit data / 10-bit address build
    load16w(10'h000, 16'h0001); load16w(10'h001, 16'h0100);
    load16w(10'h002, 16'h0003); load16w(10'h003, 16'h0101);
    load16w(10'h004, 16'h0009); load16w(10'h005, 16'h000A);
    load16w(10'h006, 16'h03FF); load16w(10'h3FF, 16'h0008);
    load16w(10'h100, 16'hFFFF); load16w(10'h101, 16'h0001);
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (8) @(negedge clk);
    chk("w16_dec_acc", acc16, 16'hFFFF);
    chk("w16_dec_carry", carry16, 1);
    chk("w16_dec_sign", sign16, 1);
    repeat (3) @(negedge clk);
    chk("w16_jmp_pc", pc16, 10'h3FF);
    @(negedge clk);
    chk("w16_pc_wrap", pc16, 10'h000);
    @(negedge clk);
    chk("w16_inc_acc", acc16, 16'h0000);
    chk("w16_inc_zero", zero16, 1);
    chk("w16_inc_carry", carry16, 1);
    rst16 = 1'b0;
    #1;
    chk("w16_rst_pc", pc16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
